// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared types and constants for the audio PWM output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    typedef enum logic [1:0] {
        MUTED = 2'd0,
        RAMP  = 2'd1,
        RUN   = 2'd2
    } ramp_state_e;

    localparam int MIDSCALE = 128;
    localparam int GAIN_MAX = 8;
    localparam int PWM_BITS = 8;

    // Gain the ramp is heading for; volumes above full scale clamp to GAIN_MAX.
    function automatic logic [3:0] gain_target(input logic mute_i, input logic [3:0] vol_i);
        if (mute_i || (vol_i == 4'd0)) begin
            return 4'd0;
        end
        if (vol_i > 4'(GAIN_MAX)) begin
            return 4'(GAIN_MAX);
        end
        return vol_i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_pwm_out_gain_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : gain_ramp
//  Description : Soft mute / volume ramp FSM, gain register and amplifier enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module gain_ramp
    import audio_pkg::*;
#(
    parameter int RAMP_PERIODS = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] target_i,
    input  logic       boundary_i,
    output logic [3:0] gain_o,
    output logic       aud_sd_o
);

    localparam int              c_CNT_W   = 10;
    localparam logic [c_CNT_W-1:0] c_TICK_AT = c_CNT_W'(RAMP_PERIODS - 1);

    ramp_state_e        state_q, state_d;
    logic [c_CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [3:0]         gain_q, gain_d;
    logic               aud_sd_q, aud_sd_d;
    logic               w_ramp_tick;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= MUTED;
            per_cnt_q <= '0;
            gain_q    <= 4'd0;
            aud_sd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            gain_q    <= gain_d;
            aud_sd_q  <= aud_sd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUTED: begin
                if (target_i != 4'd0) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (gain_q == target_i) begin
                    state_d = (target_i == 4'd0) ? MUTED : RUN;
                end
            end
            RUN: begin
                if (target_i != gain_q) begin
                    state_d = RAMP;
                end
            end
            default: state_d = MUTED;
        endcase
    end

    assign w_ramp_tick = boundary_i && (per_cnt_q == c_TICK_AT);

    // Period counter only runs while ramping, so every ramp starts a fresh full step.
    always_comb begin
        per_cnt_d = per_cnt_q;
        gain_d    = gain_q;
        aud_sd_d  = (state_q != MUTED);
        if (state_q != RAMP) begin
            per_cnt_d = '0;
        end else if (boundary_i) begin
            per_cnt_d = w_ramp_tick ? '0 : per_cnt_q + c_CNT_W'(1);
        end
        if ((state_q == RAMP) && w_ramp_tick) begin
            if (gain_q < target_i) begin
                gain_d = gain_q + 4'd1;
            end else if (gain_q > target_i) begin
                gain_d = gain_q - 4'd1;
            end
        end
        if (state_q == MUTED) begin
            gain_d = 4'd0;
        end
    end

    assign gain_o   = gain_q;
    assign aud_sd_o = aud_sd_q;

endmodule
`default_nettype wire

// File: rtl/audio_pwm_out.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pwm_out
//  Description : Music/effect mixer with ducking, ramped gain and 1-bit PWM out.
//                Define AUDIO_DELTA_SIGMA_EN for first-order delta-sigma output.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_pwm_out
    import audio_pkg::*;
#(
    parameter int RAMP_PERIODS = 64
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [7:0] bgm_sample,
    input  logic [7:0] sfx_sample,
    input  logic       sfx_valid,
    input  logic [3:0] volume,
    input  logic       mute,
    output logic       pwm_out,
    output logic       aud_sd
);

    localparam logic [PWM_BITS-1:0] c_DUTY_MID = PWM_BITS'(MIDSCALE);
    localparam logic [PWM_BITS-1:0] c_CNT_LAST = {PWM_BITS{1'b1}};

    logic signed [8:0]    w_b, w_s, w_b_half;
    logic signed [9:0]    w_mix;
    logic signed [7:0]    w_mix_sat;
    logic signed [11:0]   w_prod;
    logic [7:0]           w_duty_next;
    logic [3:0]           w_gain, w_target;
    logic                 w_boundary, w_aud_sd;
    logic                 w_unused_prod;

    logic signed [7:0]    mix_q;
    logic [PWM_BITS-1:0]  duty_next_q, duty_q, pwm_cnt_q;

    assign w_b      = $signed({1'b0, bgm_sample}) - 9'sd128;
    assign w_s      = $signed({1'b0, sfx_sample}) - 9'sd128;
    assign w_b_half = w_b >>> 1;

    // Ducking halves the music before the effect is added on top.
    assign w_mix = sfx_valid ? ($signed({w_b_half[8], w_b_half}) + $signed({w_s[8], w_s}))
                             : $signed({w_b[8], w_b});

    always_comb begin
        w_mix_sat = w_mix[7:0];
        if (w_mix > 10'sd127) begin
            w_mix_sat = 8'sd127;
        end else if (w_mix < -10'sd128) begin
            w_mix_sat = -8'sd128;
        end
    end

    // |mix * gain| <= 1024, so bits [10:3] are exactly floor(prod / 8).
    assign w_prod        = $signed({{4{mix_q[7]}}, mix_q}) * $signed({8'd0, w_gain});
    assign w_duty_next   = {~w_prod[10], w_prod[9:3]};
    assign w_unused_prod = ^{w_prod[11], w_prod[2:0]};

    assign w_boundary = (pwm_cnt_q == c_CNT_LAST);
    assign w_target   = gain_target(mute, volume);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            mix_q       <= '0;
            duty_next_q <= c_DUTY_MID;
            duty_q      <= c_DUTY_MID;
            pwm_cnt_q   <= '0;
        end else begin
            mix_q       <= w_mix_sat;
            duty_next_q <= w_duty_next;
            pwm_cnt_q   <= pwm_cnt_q + PWM_BITS'(1);
            if (w_boundary) begin
                duty_q <= duty_next_q;
            end
        end
    end

    gain_ramp #(
        .RAMP_PERIODS (RAMP_PERIODS)
    ) u_ramp (
        .clk_i      (clk_in),
        .rst_ni     (reset_in),
        .target_i   (w_target),
        .boundary_i (w_boundary),
        .gain_o     (w_gain),
        .aud_sd_o   (w_aud_sd)
    );

`ifdef AUDIO_DELTA_SIGMA_EN
    logic [PWM_BITS:0] acc_q, acc_d;

    always_comb begin
        acc_d = '0;
        if (w_aud_sd) begin
            acc_d = {1'b0, acc_q[PWM_BITS-1:0]} + {1'b0, duty_q};
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign pwm_out = acc_q[PWM_BITS];
`else
    logic pwm_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= (pwm_cnt_q < duty_q);
        end
    end

    assign pwm_out = pwm_q;
`endif

    assign aud_sd = w_aud_sd;

endmodule
`default_nettype wire

// File: tb/tb_audio_pwm_out.sv
// Directed + randomized bench for audio_pwm_out with RAMP_PERIODS = 2.
module tb_audio_pwm_out;

    logic       clk_in = 1'b0;
    logic       reset_in = 1'b0;
    logic [7:0] bgm_sample = 8'd128;
    logic [7:0] sfx_sample = 8'd128;
    logic       sfx_valid = 1'b0;
    logic [3:0] volume = 4'd8;
    logic       mute = 1'b0;
    logic       pwm_out;
    logic       aud_sd;
    logic [3:0] gain_probe;

    int n_checks = 0;
    int n_fails  = 0;

    audio_pwm_out #(.RAMP_PERIODS(2)) dut (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .bgm_sample (bgm_sample),
        .sfx_sample (sfx_sample),
        .sfx_valid  (sfx_valid),
        .volume     (volume),
        .mute       (mute),
        .pwm_out    (pwm_out),
        .aud_sd     (aud_sd)
    );

    assign gain_probe = dut.u_ramp.gain_q;

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic count_high(output int c);
        c = 0;
        repeat (256) begin
            @(posedge clk_in);
            #1;
            c += int'(pwm_out);
        end
    endtask

    task automatic measure(input string tag, input int exp);
        int c;
        tick(300);
        count_high(c);
        check(tag, c, exp);
    endtask

    task automatic wait_gain(input int g, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (int'(gain_probe) == g) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    function automatic int model_target(input bit m, input int vol);
        if (m || vol == 0) return 0;
        return (vol > 8) ? 8 : vol;
    endfunction

    function automatic int model_duty(input int bgm, input int sfx, input bit v, input int g);
        int b, s, m;
        b = bgm - 128;
        s = sfx - 128;
        m = v ? ((b >>> 1) + s) : b;
        if (m > 127) m = 127;
        if (m < -128) m = -128;
        return ((m * g) >>> 3) + 128;
    endfunction

    initial begin
        bit ok;
        bit bad;
        int c;
        int vol, g, rb, rs;
        bit rv;
        logic prev;

        #23;
        check("rst_pwm", pwm_out, 0);
        check("rst_sd", aud_sd, 0);
        check("rst_gain", gain_probe, 0);

        @(negedge clk_in);
        reset_in = 1'b1;
        tick(2);
        check("sd_rise", aud_sd, 1);
        tick(4093);
        check("gain_pre_full", gain_probe, 7);
        tick(1);
        check("gain_full", gain_probe, 8);
        tick(10);
        count_high(c);
        check("idle_mid", c, 128);

        bgm_sample = 8'd255;
        measure("bgm_max", 255);
        bgm_sample = 8'd0;
        measure("bgm_min", 0);

        sfx_valid = 1'b1;
        bgm_sample = 8'd255; sfx_sample = 8'd255;
        measure("sat_pos", 255);
        bgm_sample = 8'd0; sfx_sample = 8'd0;
        measure("sat_neg", 0);
        sfx_valid = 1'b0;

        bgm_sample = 8'd128;
        volume = 4'd4;
        wait_gain(4, 3000, ok);
        check("vol4_reach", ok, 1);
        bgm_sample = 8'd200;
        measure("vol4_pos", 164);
        bgm_sample = 8'd56;
        measure("vol4_neg", 92);

        for (int k = 0; k < 6; k++) begin
            vol = $urandom_range(1, 15);
            g   = model_target(1'b0, vol);
            volume = 4'(vol);
            wait_gain(g, 5000, ok);
            check("rnd_gain", ok, 1);
            rb = $urandom_range(0, 255);
            rs = $urandom_range(0, 255);
            rv = 1'($urandom_range(0, 1));
            bgm_sample = 8'(rb);
            sfx_sample = 8'(rs);
            sfx_valid  = rv;
            measure("rnd_duty", model_duty(rb, rs, rv, g));
        end

        bgm_sample = 8'd128; sfx_valid = 1'b0;
        volume = 4'd8;
        wait_gain(8, 5000, ok);
        check("pre_mute_full", ok, 1);
        tick(5);
        mute = 1'b1;
        wait_gain(7, 1100, ok);
        check("mute_first_step", ok, 1);
        tick(511);
        check("mute_step_hold", gain_probe, 7);
        tick(1);
        check("mute_step", gain_probe, 6);

        wait_gain(3, 3000, ok);
        check("mute_reach3", ok, 1);
        mute = 1'b0;
        bad = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            tick(1);
            if (aud_sd !== 1'b1) bad = 1'b1;
            if (gain_probe == 4'd8) begin
                ok = 1'b1;
                break;
            end
        end
        check("unmute_gain", ok, 1);
        check("unmute_sd_drop", bad, 0);

        tick(5);
        mute = 1'b1;
        wait_gain(0, 5000, ok);
        check("remute_reach0", ok, 1);
        check("remute_sd_hold", aud_sd, 1);
        tick(2);
        check("remute_sd_off", aud_sd, 0);
        count_high(c);
`ifdef AUDIO_DELTA_SIGMA_EN
        check("muted_duty", c, 0);
`else
        check("muted_duty", c, 128);
`endif

        mute = 1'b0;
        tick(2);
        check("restart_sd", aud_sd, 1);
`ifdef AUDIO_DELTA_SIGMA_EN
        tick(1);
        prev = pwm_out;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (pwm_out === prev) bad = 1'b1;
            prev = pwm_out;
        end
        check("ds_alternate", bad, 0);
`endif

        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (pwm_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check("pre_async_high", ok, 1);
        #2;
        reset_in = 1'b0;
        #1;
        check("async_pwm", pwm_out, 0);
        check("async_sd", aud_sd, 0);
        check("async_gain", gain_probe, 0);
        tick(2);
        reset_in = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
